// File: rtl/ip_codma_pkg.sv
// Shared types for the codma read path: engine state and error codes.
package ip_codma_pkg;

  typedef enum logic [2:0] {
    RD_IDLE = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    RD_DONE = 3'd3,
    RD_ERR  = 3'd4
  } rd_eng_state_t;

  typedef enum logic [1:0] {
    RD_ERR_NONE    = 2'd0,
    RD_ERR_BUS     = 2'd1,
    RD_ERR_LEN     = 2'd2,
    RD_ERR_TIMEOUT = 2'd3
  } rd_err_t;

  // Words a beat contributes when `remaining` words are still outstanding.
  function automatic int rd_beat_take(input int remaining, input int beat_words);
    return (remaining < beat_words) ? remaining : beat_words;
  endfunction

endpackage

// File: rtl/ip_codma_rd_engine_if.sv
// Memory-bus side of the codma read engine (engine = master, bus = slave).
interface ip_codma_rd_engine_if #(
  parameter int WORD_W     = 32,
  parameter int BEAT_WORDS = 2,
  parameter int MAX_WORDS  = 8
);
  localparam int CW = $clog2(MAX_WORDS + 1);

  // Handshake: req_o stays high until the cycle grant_i is seen; after that
  // every cycle with read_valid_i high delivers one beat (no backpressure).
  logic                         req_o;
  logic                         grant_i;
  logic [CW-1:0]                len_o;
  logic                         read_valid_i;
  logic [WORD_W*BEAT_WORDS-1:0] read_data_i;
  logic                         bus_error_i;

  modport master (
    output req_o, len_o,
    input  grant_i, read_valid_i, read_data_i, bus_error_i
  );

  modport slave (
    input  req_o, len_o,
    output grant_i, read_valid_i, read_data_i, bus_error_i
  );
endinterface

// File: rtl/ip_codma_rd_watchdog.sv
// Stall counter for the read engine; expires after TIMEOUT_CYC idle cycles.
module ip_codma_rd_watchdog #(
  parameter  int TIMEOUT_CYC = 256,
  localparam int TW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Count 0 is the first waiting cycle, so the last allowed one is TIMEOUT_CYC-1.
  assign expired_o = enable_i && (cnt_q == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ip_codma_rd_engine.sv
// codma read engine: variable-length multi-word read into a word buffer.
// Optional stall watchdog enabled by defining CODMA_RD_TIMEOUT_EN.
module ip_codma_rd_engine
  import ip_codma_pkg::*;
#(
  parameter  int WORD_W      = 32,
  parameter  int BEAT_WORDS  = 2,
  parameter  int MAX_WORDS   = 8,
  parameter  int TIMEOUT_CYC = 256,
  localparam int CW          = $clog2(MAX_WORDS + 1),
  localparam int AW          = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              start_i,
  input  logic [CW-1:0]                     len_i,
  input  logic                              stop_i,
  ip_codma_rd_engine_if.master              bus,
  output logic [MAX_WORDS-1:0][WORD_W-1:0]  data_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o,
  output logic [1:0]                        err_code_o,
  output rd_eng_state_t                     state_o,
  output logic [CW-1:0]                     count_o
);

  rd_eng_state_t                    state_q, state_d;
  logic [CW-1:0]                    len_q, len_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [MAX_WORDS-1:0][WORD_W-1:0] data_q, data_d;
  logic                             err_q, err_d;
  rd_err_t                          code_q, code_d;
  logic                             wd_expired;

  logic len_ok;
  assign len_ok = (len_i != '0) && (int'(len_i) <= MAX_WORDS);

  always_comb begin
    int idx;
    int take;
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    code_d  = code_q;
    idx     = 0;
    take    = 0;

    if (state_q != RD_IDLE && stop_i) begin
      state_d = RD_IDLE;
    end else if ((state_q == RD_REQ || state_q == RD_DATA) && bus.bus_error_i) begin
      state_d = RD_ERR;
      err_d   = 1'b1;
      code_d  = RD_ERR_BUS;
    end else begin
      unique case (state_q)
        RD_IDLE: begin
          if (start_i) begin
            if (len_ok) begin
              state_d = RD_REQ;
              len_d   = len_i;
              cnt_d   = '0;
              err_d   = 1'b0;
              code_d  = RD_ERR_NONE;
            end else begin
              state_d = RD_ERR;
              err_d   = 1'b1;
              code_d  = RD_ERR_LEN;
            end
          end
        end
        RD_REQ: begin
          if (bus.grant_i) begin
            state_d = RD_DATA;
          end else if (wd_expired) begin
            state_d = RD_ERR;
            err_d   = 1'b1;
            code_d  = RD_ERR_TIMEOUT;
          end
        end
        RD_DATA: begin
          if (bus.read_valid_i) begin
            // Words beyond the command length in a partial beat are dropped.
            for (int k = 0; k < BEAT_WORDS; k++) begin
              idx = int'(cnt_q) + k;
              if (idx < int'(len_q)) begin
                data_d[idx[AW-1:0]] = bus.read_data_i[k*WORD_W +: WORD_W];
              end
            end
            take  = rd_beat_take(int'(len_q) - int'(cnt_q), BEAT_WORDS);
            cnt_d = cnt_q + CW'(take);
            if (cnt_d == len_q) state_d = RD_DONE;
          end else if (wd_expired) begin
            state_d = RD_ERR;
            err_d   = 1'b1;
            code_d  = RD_ERR_TIMEOUT;
          end
        end
        RD_DONE: state_d = RD_IDLE;
        RD_ERR:  state_d = RD_IDLE;
        default: state_d = RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RD_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= RD_ERR_NONE;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

`ifdef CODMA_RD_TIMEOUT_EN
  logic wd_clear, wd_enable;
  assign wd_enable = (state_q == RD_REQ) || (state_q == RD_DATA);
  assign wd_clear  = (state_q == RD_IDLE && start_i) ||
                     (state_q == RD_REQ  && bus.grant_i) ||
                     (state_q == RD_DATA && bus.read_valid_i);

  ip_codma_rd_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  assign bus.req_o  = (state_q == RD_REQ);
  assign bus.len_o  = len_q;
  assign data_o     = data_q;
  assign busy_o     = (state_q != RD_IDLE);
  assign done_o     = (state_q == RD_DONE);
  assign err_o      = err_q;
  assign err_code_o = code_q;
  assign state_o    = state_q;
  assign count_o    = cnt_q;

endmodule

// File: tb/tb_ip_codma_rd_engine.sv
// Randomized bench for ip_codma_rd_engine against a word-stream buffer model.
module tb_ip_codma_rd_engine;
  import ip_codma_pkg::*;

  localparam int WORD_W     = 32;
  localparam int BEAT_WORDS = 2;
  localparam int MAX_WORDS  = 8;
  localparam int CW         = $clog2(MAX_WORDS + 1);
  localparam int BW         = WORD_W * BEAT_WORDS;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset_i, start_i, stop_i;
  logic [CW-1:0] len_i;
  logic [MAX_WORDS-1:0][WORD_W-1:0] data_o;
  logic busy_o, done_o, err_o;
  logic [1:0] err_code_o;
  rd_eng_state_t state_o;
  logic [CW-1:0] count_o;

  always #5 clk = ~clk;

  ip_codma_rd_engine_if #(.WORD_W(WORD_W), .BEAT_WORDS(BEAT_WORDS), .MAX_WORDS(MAX_WORDS)) bus_if ();

  ip_codma_rd_engine #(
    .WORD_W(WORD_W), .BEAT_WORDS(BEAT_WORDS), .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYC(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .len_i(len_i), .stop_i(stop_i),
    .bus(bus_if), .data_o(data_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .err_code_o(err_code_o), .state_o(state_o), .count_o(count_o)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [WORD_W-1:0] exp_buf [MAX_WORDS];
  logic [WORD_W-1:0] exp_q[$];
  logic [BW-1:0]     beat_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_buffer(input string tag);
    for (int i = 0; i < MAX_WORDS; i++) check_eq($sformatf("%s_w%0d", tag, i), 64'(data_o[i]), 64'(exp_buf[i]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; stop_i = 1'b0; len_i = '0;
    bus_if.grant_i = 1'b0; bus_if.read_valid_i = 1'b0; bus_if.bus_error_i = 1'b0;
    bus_if.read_data_i = {$urandom, $urandom};
  endtask

  task automatic start_cmd(input int len);
    start_i = 1'b1; len_i = CW'(len);
    step();
    start_i = 1'b0; len_i = CW'($urandom);
  endtask

  // Full transfer using the beats preloaded in beat_q.
  task automatic run_xfer(input int len, input int grant_dly, input int max_gap, input bit extra_beat);
    start_cmd(len);
    check_eq("req_after_start", 64'(bus_if.req_o), 64'd1);
    check_eq("len_o_latched", 64'(bus_if.len_o), 64'(len));
    check_eq("err_cleared_on_start", {62'd0, err_o, 1'b0} | 64'(err_code_o), 64'd0);
    repeat (grant_dly) begin
      bus_if.read_valid_i = 1'($urandom_range(0, 1));
      bus_if.read_data_i  = {$urandom, $urandom};
      step();
      check_eq("req_held", 64'(bus_if.req_o), 64'd1);
    end
    // valid alongside grant must be ignored
    bus_if.grant_i = 1'b1; bus_if.read_valid_i = 1'b1; bus_if.read_data_i = {$urandom, $urandom};
    step();
    bus_if.grant_i = 1'b0; bus_if.read_valid_i = 1'b0;
    check_eq("req_drop_after_grant", 64'(bus_if.req_o), 64'd0);
    exp_q.delete();
    while (beat_q.size() != 0) begin
      logic [BW-1:0] b;
      b = beat_q.pop_front();
      repeat ($urandom_range(0, max_gap)) step();
      bus_if.read_valid_i = 1'b1; bus_if.read_data_i = b;
      for (int k = 0; k < BEAT_WORDS; k++) exp_q.push_back(b[k*WORD_W +: WORD_W]);
      step();
      bus_if.read_valid_i = 1'b0;
      check_eq("done_pulse", 64'(done_o), (beat_q.size() == 0) ? 64'd1 : 64'd0);
    end
    if (extra_beat) begin
      bus_if.read_valid_i = 1'b1; bus_if.read_data_i = {$urandom, $urandom};
    end
    step();
    bus_if.read_valid_i = 1'b0;
    check_eq("done_one_cycle", 64'(done_o), 64'd0);
    check_eq("idle_after_done", 64'(busy_o), 64'd0);
    check_eq("count_final", 64'(count_o), 64'(len));
    for (int i = 0; i < len; i++) exp_buf[i] = exp_q[i];
    check_buffer("buf");
  endtask

  task automatic load_random_beats(input int len);
    beat_q.delete();
    for (int i = 0; i < (len + BEAT_WORDS - 1) / BEAT_WORDS; i++) beat_q.push_back({$urandom, $urandom});
  endtask

  task automatic bad_len(input int len);
    start_cmd(len);
    check_eq("badlen_err", 64'(err_o), 64'd1);
    check_eq("badlen_code", 64'(err_code_o), 64'd2);
    check_eq("badlen_no_req", 64'(bus_if.req_o), 64'd0);
    step();
    check_eq("badlen_idle", 64'(busy_o), 64'd0);
    check_eq("badlen_sticky", 64'(err_o), 64'd1);
    check_eq("badlen_no_req2", 64'(bus_if.req_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    reset_i = 1'b1;
    repeat (2) step();
    reset_i = 1'b0;
    for (int i = 0; i < MAX_WORDS; i++) exp_buf[i] = '0;
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_req", 64'(bus_if.req_o), 64'd0);
    check_eq("rst_err", 64'(err_o), 64'd0);
    check_eq("rst_code", 64'(err_code_o), 64'd0);
    check_eq("rst_len", 64'(bus_if.len_o), 64'd0);
    check_buffer("rst_buf");

    // Directed: len=8, grant after 3 cycles, four fixed beats.
    beat_q = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
               64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004};
    run_xfer(8, 3, 0, 1'b0);
    check_eq("t1_w0", 64'(data_o[0]), 64'h0000_0001);
    check_eq("t1_w1", 64'(data_o[1]), 64'h1111_0000);
    check_eq("t1_w7", 64'(data_o[7]), 64'h4444_0000);

    // Directed: len=3 partial last beat.
    beat_q = '{64'h5555_5555_6666_6666, 64'hAAAA_AAAA_BBBB_BBBB};
    run_xfer(3, 0, 1, 1'b1);
    check_eq("t2_w2", 64'(data_o[2]), 64'hBBBB_BBBB);
    check_eq("t2_w3_stale", 64'(data_o[3]), 64'h2222_0000);

    // Bad lengths, then a valid command clears the error.
    bad_len(0);
    bad_len(9);
    load_random_beats(2);
    run_xfer(2, 1, 0, 1'b0);

    // stop together with bus_error after first beat of len=6.
    begin
      logic [BW-1:0] b;
      start_cmd(6);
      bus_if.grant_i = 1'b1; step(); bus_if.grant_i = 1'b0;
      b = {$urandom, $urandom};
      bus_if.read_valid_i = 1'b1; bus_if.read_data_i = b; step(); bus_if.read_valid_i = 1'b0;
      exp_buf[0] = b[WORD_W-1:0]; exp_buf[1] = b[BW-1:WORD_W];
      stop_i = 1'b1; bus_if.bus_error_i = 1'b1; step(); stop_i = 1'b0; bus_if.bus_error_i = 1'b0;
      check_eq("stop_idle", 64'(busy_o), 64'd0);
      check_eq("stop_no_err", 64'(err_o), 64'd0);
      check_eq("stop_no_done", 64'(done_o), 64'd0);
      check_buffer("stop_buf");
    end

    // bus_error alone in DATA.
    start_cmd(4);
    bus_if.grant_i = 1'b1; step(); bus_if.grant_i = 1'b0;
    bus_if.bus_error_i = 1'b1; step(); bus_if.bus_error_i = 1'b0;
    check_eq("buserr_err", 64'(err_o), 64'd1);
    check_eq("buserr_code", 64'(err_code_o), 64'd1);
    step();
    check_eq("buserr_idle", 64'(busy_o), 64'd0);
    check_eq("buserr_sticky", 64'(err_code_o), 64'd1);
    check_eq("buserr_no_done", 64'(done_o), 64'd0);

`ifdef CODMA_RD_TIMEOUT_EN
    start_cmd(4);
    repeat (15) begin
      step();
      check_eq("wd_not_yet", 64'(err_o), 64'd0);
    end
    step();
    check_eq("wd_err", 64'(err_o), 64'd1);
    check_eq("wd_code", 64'(err_code_o), 64'd3);
    step();
`endif

    // Randomized transfers, with occasional illegal lengths.
    for (int t = 0; t < 40; t++) begin
      int len;
      if ($urandom_range(0, 7) == 0) begin
        bad_len(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_WORDS + 1, (1 << CW) - 1));
      end
      len = $urandom_range(1, MAX_WORDS);
      load_random_beats(len);
      run_xfer(len, $urandom_range(0, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Reset mid-DATA returns everything to reset values.
    start_cmd(8);
    bus_if.grant_i = 1'b1; step(); bus_if.grant_i = 1'b0;
    bus_if.read_valid_i = 1'b1; bus_if.read_data_i = {$urandom, $urandom}; step();
    bus_if.read_data_i = {$urandom, $urandom};
    reset_i = 1'b1; step(); reset_i = 1'b0; bus_if.read_valid_i = 1'b0;
    for (int i = 0; i < MAX_WORDS; i++) exp_buf[i] = '0;
    check_eq("mrst_busy", 64'(busy_o), 64'd0);
    check_eq("mrst_req", 64'(bus_if.req_o), 64'd0);
    check_eq("mrst_done", 64'(done_o), 64'd0);
    check_eq("mrst_err", 64'(err_o), 64'd0);
    check_eq("mrst_code", 64'(err_code_o), 64'd0);
    check_eq("mrst_len", 64'(bus_if.len_o), 64'd0);
    check_eq("mrst_count", 64'(count_o), 64'd0);
    check_buffer("mrst_buf");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ip_codma_rd_engine.md
# ip_codma_rd_engine

Parametrised read engine for the codma datapath: accepts a read command of 1..MAX_WORDS words, arbitrates for the memory bus, captures multi-word beats into an output word buffer, and reports completion or a coded error. It sits between the DMA control FSM and the memory bus master port. It replaces the fixed-size read machine and adds arbitrary lengths, partial last beats, length checking, an abort path and an optional stall watchdog.

## Interface
- `WORD_W`, 32, width of one buffered word
- `BEAT_WORDS`, 2, words per bus beat; bus data width = WORD_W*BEAT_WORDS
- `MAX_WORDS`, 8, buffer depth in words, ≥ BEAT_WORDS
- `TIMEOUT_CYC`, 256, watchdog limit in cycles; only used with the macro
- `clk_i` in 1: clock
- `reset_i` in 1: synchronous, active-high reset
- `start_i` in 1: command strobe, sampled only in IDLE
- `len_i` in CW = $clog2(MAX_WORDS+1): command length in words
- `stop_i` in 1: abort request
- `req_o` out 1: bus request
- `grant_i` in 1: bus grant
- `len_o` out CW: latched length presented to the bus
- `read_valid_i` in 1: beat valid
- `read_data_i` in WORD_W*BEAT_WORDS: beat data; word k is bits [k*WORD_W +: WORD_W]
- `bus_error_i` in 1: bus error
- `data_o` out [MAX_WORDS-1:0][WORD_W-1:0]: word buffer
- `busy_o` out 1: high in every state except IDLE
- `done_o` out 1: one-cycle completion pulse
- `err_o` out 1: sticky error flag
- `err_code_o` out 2: 0 none, 1 bus, 2 bad length, 3 timeout

## Operation
- States (`rd_eng_state_t`): IDLE, REQ, DATA, DONE, ERR.
- **IDLE**
  - `start_i` with 1 ≤ `len_i` ≤ MAX_WORDS: latch `len_i` into `len_o`, clear word count, clear `err_o`/`err_code_o`, go to REQ.
  - `start_i` with any other length: go to ERR with code 2.
- **REQ**
  - `req_o`=1.
  - `grant_i` goes to DATA.
- **DATA**
  - `req_o`=0.
  - On each `read_valid_i`, write word k of the beat to `data_o[count+k]` for every k < BEAT_WORDS with count+k < len.
  - Count increments by min(BEAT_WORDS, len−count).
  - When the updated count equals len, go to DONE.
  - Excess words and excess beats are discarded.
- **DONE**
  - `done_o`=1 for this cycle only.
  - Go to IDLE.
- **ERR**
  - Set `err_o`=1 and latch the code.
  - Go to IDLE.
  - `err_o`/`err_code_o` hold until the next accepted `start_i` or reset.
- `bus_error_i` in REQ or DATA goes to ERR with code 1.
- Priority each cycle: reset > `stop_i` > `bus_error_i` > normal transitions.
- `stop_i` in any non-IDLE state:
  - Next state is IDLE, with no `done_o` and no error.
  - The buffer keeps any words already written.
- `read_valid_i` outside DATA is ignored.
- `data_o` is never cleared except by reset. Stale words above len are left unchanged.

## Timing
- Reset values:
  - State IDLE.
  - `req_o`, `busy_o`, `done_o`, `err_o` all 0.
  - `err_code_o`, `len_o`, `data_o`, count all 0.
- `reset_i` asserted mid-transfer returns the engine to IDLE on the next edge and discards the transfer.
- Registered outputs; all outputs are decoded from registered state or registers.
- `start_i` at edge n gives `req_o`=1 from cycle n+1.
- `grant_i` at edge m gives `req_o`=0 from cycle m+1.
- A beat sampled at edge t is visible on `data_o` from t+1.
- The final beat at edge t gives `done_o` in cycle t+1 and IDLE in t+2.
- A new `start_i` is accepted in cycle t+2 at the earliest.
- Minimum command-to-done latency is 1 (REQ) + 1 (first beat) + ceil(len/BEAT_WORDS) − 1 + 1 cycles, assuming grant and valid are held high.
- `read_valid_i` on the same edge as `grant_i` is ignored; data is accepted only in DATA.

## Configuration
- `CODMA_RD_TIMEOUT_EN` defined:
  - A cycle counter runs in REQ and DATA.
  - It clears on entry to REQ and on every accepted beat.
  - Reaching TIMEOUT_CYC with no grant and no beat goes to ERR with code 3.
  - `bus_error_i` takes priority over the timeout in the same cycle.
- Macro undefined:
  - No counter logic is present.
  - The engine waits indefinitely.
  - Code 3 is never produced.

## Structure
- `ip_codma_pkg` gains `rd_eng_state_t` (enum, 3 bits) and `rd_err_t` (2-bit enum: RD_ERR_NONE, RD_ERR_BUS, RD_ERR_LEN, RD_ERR_TIMEOUT).
- One sub-module, `ip_codma_rd_watchdog`, holds the timeout counter. It has clear, enable and expired ports and is instantiated only under the macro.

## Test plan
- WORD_W=32, BEAT_WORDS=2, len=8, grant after 3 cycles, 4 beats 0x1111_0000_0000_0001..0x4444_0000_0000_0004 -> `data_o[0]`=0x00000001, `data_o[1]`=0x11110000 … `data_o[7]`=0x44440000; `done_o` for exactly one cycle, 1 cycle after beat 4.
- len=3, 2 beats where beat 2 = 0xAAAA_AAAA_BBBB_BBBB -> `data_o[2]`=0xBBBBBBBB; `data_o[3]` unchanged; count=3; done.
- len=0 and len=9 -> ERR with `err_code_o`=2, no `req_o`; the next valid start clears `err_o`.
- `bus_error_i` together with `stop_i` after beat 1 of len=6 -> IDLE, `err_o`=0, no `done_o`; `bus_error_i` alone -> `err_code_o`=1.
- `CODMA_RD_TIMEOUT_EN` with TIMEOUT_CYC=16: grant never arrives -> `err_code_o`=3 at cycle 16 after REQ entry; `reset_i` pulsed mid-DATA -> every output at its reset value on the next cycle.
